// File: rtl/voting_machine_multi.sv
// Multi-candidate ballot unit: hold-qualified, release-before-revote voting with saturating tallies.
// Optional running total shown in idle tally mode is enabled by defining VM_TOTAL_EN.
module voting_machine_multi #(
  parameter int NUM_CAND    = 4,
  parameter int COUNT_W     = 8,
  parameter int HOLD_CYCLES = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CAND-1:0] cand,
  input  logic                mode,
  output logic [COUNT_W-1:0]  led,
  output logic                vote_ack,
  output logic                invalid
);

  localparam int IDX_W  = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [COUNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [NUM_CAND-1:0] CAND_ONE = NUM_CAND'(1);

  typedef enum logic [1:0] {IDLE, HOLD, COMMIT, WAIT_REL} state_e;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                armed_q, armed_d;
  logic [COUNT_W-1:0]  cnt_q [NUM_CAND];
  logic [COUNT_W-1:0]  led_q, led_d;
  logic                invalid_q;

  logic                any, onehot, commit_inc;
  logic [IDX_W-1:0]    cand_idx;
  logic [COUNT_W-1:0]  total_disp;

  assign any        = |cand;
  assign onehot     = any && ((cand & (cand - CAND_ONE)) == '0);
  assign commit_inc = (state_q == COMMIT) && (cnt_q[idx_q] != CNT_MAX);

  always_comb begin
    cand_idx = '0;
    for (int k = 0; k < NUM_CAND; k++) begin
      if (cand[k]) cand_idx = IDX_W'(k);
    end
  end

  // armed_q drops on every tally cycle so a button held across the mode switch needs a release.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    armed_d = mode ? 1'b0 : (any ? armed_q : 1'b1);
    if (mode) begin
      state_d = IDLE;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (armed_q && onehot) begin
            idx_d   = cand_idx;
            hold_d  = HOLD_W'(1);
            state_d = (HOLD_CYCLES == 1) ? COMMIT : HOLD;
          end else if (armed_q && any) begin
            state_d = WAIT_REL;
          end
        end
        HOLD: begin
          if (cand == (CAND_ONE << idx_q)) begin
            hold_d = hold_q + HOLD_W'(1);
            if (hold_q + HOLD_W'(1) == HOLD_W'(HOLD_CYCLES)) state_d = COMMIT;
          end else begin
            state_d = any ? WAIT_REL : IDLE;
          end
        end
        COMMIT:   state_d = WAIT_REL;
        WAIT_REL: if (!any) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

`ifdef VM_TOTAL_EN
  localparam int TOT_W = COUNT_W + $clog2(NUM_CAND);
  logic [TOT_W-1:0] total_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           total_q <= '0;
    else if (commit_inc) total_q <= total_q + TOT_W'(1);
  end

  assign total_disp = (total_q > TOT_W'(CNT_MAX)) ? CNT_MAX : total_q[COUNT_W-1:0];
`else
  assign total_disp = '0;
`endif

  always_comb begin
    led_d = '0;
    if (mode) begin
      if (onehot)    led_d = cnt_q[cand_idx];
      else if (!any) led_d = total_disp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      idx_q     <= '0;
      armed_q   <= 1'b1;
      led_q     <= '0;
      invalid_q <= 1'b0;
      // NOTE: the tallies are a small register array, not RAM, so they clear with the async reset.
      for (int k = 0; k < NUM_CAND; k++) cnt_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      armed_q   <= armed_d;
      led_q     <= led_d;
      invalid_q <= !mode && any && !onehot;
      if (commit_inc) cnt_q[idx_q] <= cnt_q[idx_q] + COUNT_W'(1);
    end
  end

  assign led      = led_q;
  assign invalid  = invalid_q;
  assign vote_ack = (state_q == COMMIT);

endmodule
